// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N2 UART transmitter.
//
// A circular buffer holds up to 2**DEPTH_LOG2 bytes. A small launch FSM pops
// the head byte and presents it with a one-cycle TxD_start pulse whenever the
// transmitter is idle. It then waits for the transmitter's busy flag to drop
// before it launches the next byte.
//
// Optional feature: define UART_TX_FIFO_FLUSH_EN to add the 'flush' input.
// A flush empties the buffer in one cycle. It does not disturb the byte that
// is already in flight.
//
// Handshake with the transmitter:
//   TxD_start is a single-cycle request with TxD_data valid in the same cycle.
//   A launch happens only when TxD_busy was sampled low. The transmitter raises
//   TxD_busy the cycle after it accepts TxD_start and holds it until the frame
//   is finished. TxD_data then stays stable until the next launch.

module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef UART_TX_FIFO_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  TxD_start,
  output logic [7:0]            TxD_data,
  input  logic                  TxD_busy,
  output logic [1:0]            dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // GUARD covers the single cycle in which busy has not yet risen after a launch.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_GUARD = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   tx_start_q;
  logic [7:0]             tx_data_q;

  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    level_q,  level_d;
  logic                   overflow_q, overflow_d;

  // Storage is intentionally not reset. Only the pointers define which entries are valid.
  logic [7:0]             mem_q [DEPTH];

  logic                   full_w;
  logic                   push_w;
  logic                   drop_w;
  logic                   pop_w;

  // Accept, drop and pop decisions. They use only registered state, so a pop never frees room in the same cycle.
  always_comb begin
    full_w = (level_q == LVL_FULL);
    push_w = wr_en && !full_w;
    drop_w = wr_en && full_w;
    pop_w  = (state_q == ST_IDLE) && (level_q != '0) && !TxD_busy;
`ifdef UART_TX_FIFO_FLUSH_EN
    // A flush discards the whole queue. A concurrent write is dropped without raising overflow.
    if (flush) begin
      push_w = 1'b0;
      drop_w = 1'b0;
      pop_w  = 1'b0;
    end
`endif
  end

  // Next-state values for the pointers, the occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | drop_w;
    if (push_w) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_w, pop_w})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
`ifdef UART_TX_FIFO_FLUSH_EN
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
`endif
  end

  // Pointer, level and overflow registers. Reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage write port. A write during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && push_w) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Launch FSM with registered TxD_start and TxD_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop_w) begin
            state_q    <= ST_START;
            tx_start_q <= 1'b1;
            tx_data_q  <= mem_q[rd_ptr_q];
          end
        end
        ST_START: begin
          state_q <= ST_GUARD;
        end
        ST_GUARD: begin
          state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!TxD_busy) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign full      = full_w;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign TxD_start = tx_start_q;
  assign TxD_data  = tx_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo (DEPTH_LOG2 = 4).
// A behavioural transmitter raises busy the cycle after each TxD_start and
// holds it for busy_len cycles. force_busy pins busy high.

module tb_uart_tx_fifo;

  localparam int DL2   = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           wr_en;
  logic [7:0]     wr_data;
  logic           full;
  logic [DL2:0]   level;
  logic           overflow;
  logic           TxD_start;
  logic [7:0]     TxD_data;
  logic           TxD_busy;
  logic [1:0]     dbg_state;
`ifdef UART_TX_FIFO_FLUSH_EN
  logic           flush;
`endif

  uart_tx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef UART_TX_FIFO_FLUSH_EN
    .flush     (flush),
`endif
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .level     (level),
    .overflow  (overflow),
    .TxD_start (TxD_start),
    .TxD_data  (TxD_data),
    .TxD_busy  (TxD_busy),
    .dbg_state (dbg_state)
  );

  // ---------------- transmitter model (no reset) ----------------
  logic force_busy = 1'b0;
  int   busy_len   = 20;
  int   busy_cnt   = 0;

  always @(posedge clk) begin
    if (TxD_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign TxD_busy = force_busy | (busy_cnt != 0);

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int   errors      = 0;
  int   checks      = 0;
  int   m_level     = 0;
  logic m_ovf       = 1'b0;
  int   launch_cnt  = 0;
  int   cyc_n       = 0;
  int   last_launch = -100;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc_n);
    end
  endtask

  // Drive one cycle of inputs, advance one clock, then update the model and check against it.
  task automatic cyc(input logic r, input logic w, input logic [7:0] d, input logic fl);
    logic       acc;
    logic       ovs;
    logic       busy_b;
    logic [7:0] exp_b;
    rst     = r;
    wr_en   = w;
    wr_data = d;
`ifdef UART_TX_FIFO_FLUSH_EN
    flush   = fl;
`endif
    acc    = !r && !fl && w && (m_level != DEPTH);
    ovs    = !r && !fl && w && (m_level == DEPTH);
    busy_b = force_busy | (busy_cnt != 0);
    @(posedge clk);
    #1;
    cyc_n++;
    if (r) begin
      m_level     = 0;
      m_ovf       = 1'b0;
      exp_q.delete();
      last_launch = -100;
    end else if (fl) begin
      m_level = 0;
      exp_q.delete();
    end else begin
      if (acc) begin
        exp_q.push_back(d);
        m_level++;
      end
      if (ovs) m_ovf = 1'b1;
    end
    if (TxD_start) begin
      launch_cnt++;
      chk("busy_low_at_launch", int'(busy_b), 0);
      chk("launch_gap_ge3", int'((cyc_n - last_launch) >= 3), 1);
      last_launch = cyc_n;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_launch: data 0x%0h sent, nothing expected", TxD_data);
      end else begin
        exp_b = exp_q.pop_front();
        chk("tx_data_order", int'(TxD_data), int'(exp_b));
        m_level--;
      end
    end
    chk("level_vs_model", int'(level), m_level);
    chk("full_vs_model", int'(full), int'(m_level == DEPTH));
    chk("overflow_vs_model", int'(overflow), int'(m_ovf));
  endtask

  task automatic run(input int n);
    repeat (n) cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || dbg_state != 2'd0 || busy_cnt != 0 || force_busy) && k < budget) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      k++;
    end
    chk(name, int'(k < budget), 1);
  endtask

  task automatic wait_launches(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (launch_cnt < target && k < budget) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      k++;
    end
    chk(name, launch_cnt, target);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       r;
    logic       w;
    logic [7:0] d;
    int         lvl;
    logic       f;
    logic       ov;
    logic       st;
  } vec_t;

  vec_t tbl[20];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;
    int exp_total;

    // reset row with a write: the write is dropped and overflow stays 0
    tbl[0].r = 1'b1; tbl[0].w = 1'b1; tbl[0].d = 8'h99;
    tbl[0].lvl = 0; tbl[0].f = 1'b0; tbl[0].ov = 1'b0; tbl[0].st = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tbl[i].r = 1'b0; tbl[i].w = 1'b1; tbl[i].d = 8'(i);
      tbl[i].lvl = i; tbl[i].f = (i == 16); tbl[i].ov = 1'b0; tbl[i].st = 1'b0;
    end
    tbl[17].r = 1'b0; tbl[17].w = 1'b1; tbl[17].d = 8'hAA;
    tbl[17].lvl = 16; tbl[17].f = 1'b1; tbl[17].ov = 1'b1; tbl[17].st = 1'b0;
    tbl[18].r = 1'b0; tbl[18].w = 1'b0; tbl[18].d = 8'h00;
    tbl[18].lvl = 16; tbl[18].f = 1'b1; tbl[18].ov = 1'b1; tbl[18].st = 1'b0;
    tbl[19].r = 1'b0; tbl[19].w = 1'b1; tbl[19].d = 8'hBB;
    tbl[19].lvl = 16; tbl[19].f = 1'b1; tbl[19].ov = 1'b1; tbl[19].st = 1'b0;

    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
`ifdef UART_TX_FIFO_FLUSH_EN
    flush = 1'b0;
`endif

    // reset state
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_level", int'(level), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_txd_start", int'(TxD_start), 0);
    chk("rst_txd_data", int'(TxD_data), 0);
    chk("rst_state", int'(dbg_state), 0);

    // single byte into an empty FIFO: pulse seen by the transmitter two edges after the write
    cyc(1'b0, 1'b1, 8'h55, 1'b0);
    chk("lat_write_edge_start", int'(TxD_start), 0);
    chk("lat_write_edge_level", int'(level), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("lat_start", int'(TxD_start), 1);
    chk("lat_data", int'(TxD_data), 8'h55);
    chk("lat_level", int'(level), 0);
    chk("lat_state_start", int'(dbg_state), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("pulse_one_cycle", int'(TxD_start), 0);
    chk("state_guard", int'(dbg_state), 2);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("state_drain", int'(dbg_state), 3);
    chk("data_held", int'(TxD_data), 8'h55);
    wait_idle(60, "drain_55");

    // table: reset with write, fill to full under busy, then overflow
    force_busy = 1'b1;
    l0 = launch_cnt;
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].r, tbl[i].w, tbl[i].d, 1'b0);
      chk("tbl_level", int'(level), tbl[i].lvl);
      chk("tbl_full", int'(full), int'(tbl[i].f));
      chk("tbl_overflow", int'(overflow), int'(tbl[i].ov));
      chk("tbl_txd_start", int'(TxD_start), int'(tbl[i].st));
    end
    chk("no_launch_while_busy", launch_cnt, l0);

    // drain the 16 bytes: 0xAA / 0xBB must never appear
    force_busy = 1'b0;
    wait_idle(800, "drain_16");
    chk("drain_16_count", launch_cnt, l0 + 16);
    chk("overflow_sticky", int'(overflow), 1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_clears_overflow", int'(overflow), 0);

    // write and pop in the same cycle at level 5
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    chk("lvl5_before", int'(level), 5);
    force_busy = 1'b0;
    cyc(1'b0, 1'b1, 8'h35, 1'b0);
    chk("lvl5_pop_start", int'(TxD_start), 1);
    chk("lvl5_stays", int'(level), 5);
    wait_idle(300, "drain_lvl5");

    // write and pop in the same cycle when full: write dropped, overflow set
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    chk("full_before", int'(full), 1);
    chk("full_ovf_before", int'(overflow), 0);
    force_busy = 1'b0;
    cyc(1'b0, 1'b1, 8'hCC, 1'b0);
    chk("full_pop_start", int'(TxD_start), 1);
    chk("full_pop_level", int'(level), 15);
    chk("full_pop_overflow", int'(overflow), 1);
    wait_idle(800, "drain_full");

    // three bytes against a 20-cycle transmitter
    busy_len = 20;
    l0 = launch_cnt;
    cyc(1'b0, 1'b1, 8'h11, 1'b0);
    cyc(1'b0, 1'b1, 8'h22, 1'b0);
    cyc(1'b0, 1'b1, 8'h33, 1'b0);
    wait_launches(l0 + 3, 200, "three_launches");
    wait_idle(100, "drain_three");

`ifdef UART_TX_FIFO_FLUSH_EN
    // flush at level 7 with a concurrent write while a byte is in flight
    l0 = launch_cnt;
    cyc(1'b0, 1'b1, 8'h61, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'(8'h62 + i), 1'b0);
    chk("flush_level_before", int'(level), 7);
    chk("flush_state_before", int'(dbg_state), 3);
    cyc(1'b0, 1'b1, 8'h69, 1'b1);
    chk("flush_level", int'(level), 0);
    chk("flush_overflow_kept", int'(overflow), 1);
    chk("flush_state_kept", int'(dbg_state), 3);
    chk("flush_data_kept", int'(TxD_data), 8'h61);
    wait_idle(80, "drain_flush");
    chk("flush_launches", launch_cnt, l0 + 1);
`endif

    // reset in DRAIN with 4 bytes queued and busy still high
    l0 = launch_cnt;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h41 + i), 1'b0);
    chk("mid_state_drain", int'(dbg_state), 3);
    chk("mid_level4", int'(level), 4);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_start", int'(TxD_start), 0);
    chk("mid_rst_state", int'(dbg_state), 0);
    chk("mid_rst_data", int'(TxD_data), 0);
    cyc(1'b0, 1'b1, 8'h77, 1'b0);
    wait_launches(l0 + 2, 60, "after_rst_launch");
    wait_idle(60, "drain_after_rst");

    // final accounting
    exp_total = 44;
`ifdef UART_TX_FIFO_FLUSH_EN
    exp_total = 45;
`endif
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("total_launches", launch_cnt, exp_total);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port wr_en  input  1  push wr_data this cycle.
REQ-005 SHALL have port wr_data  input  8  byte to enqueue.
REQ-006 SHALL have port full  output  1  high when level == 2**DEPTH_LOG2.
REQ-007 SHALL have port level  output  DEPTH_LOG2+1  bytes currently stored.
REQ-008 SHALL have port overflow  output  1  sticky flag; a write was dropped.
REQ-009 SHALL have port TxD_start  output  1  one-cycle launch pulse to the 8N2 UART transmitter.
REQ-010 SHALL have port TxD_data  output  8  byte presented with TxD_start.
REQ-011 SHALL have port TxD_busy  input  1  transmitter busy, rises the cycle after an accepted TxD_start.

Function
REQ-012 Storage SHALL be a circular buffer with rd/wr pointers of DEPTH_LOG2 bits wrapping modulo depth; contents not reset.
REQ-013 Write SHALL be accepted iff wr_en && !full (full from registered level); a pop in the same cycle does not make room.
REQ-014 wr_en && full SHALL drop the byte and set overflow next cycle; overflow cleared only by rst.
REQ-015 level SHALL be +1 on accepted write only, -1 on pop only, unchanged on both.
REQ-016 Launch FSM SHALL have states IDLE, START, GUARD, DRAIN.
REQ-017 IDLE -> START when level != 0 && !TxD_busy: pop head into TxD_data register, TxD_start = 1 for the START cycle only.
REQ-018 START -> GUARD unconditionally; TxD_start = 0 from GUARD onward.
REQ-019 GUARD SHALL ignore TxD_busy for one cycle (covers busy rise latency), then -> DRAIN.
REQ-020 DRAIN -> IDLE when TxD_busy == 0.
REQ-021 Launch latency: byte written at edge N into an empty FIFO with TxD_busy low SHALL produce TxD_start high at cycle N+2.
REQ-022 TxD_data SHALL hold its value from START until the next START.
REQ-023 Back-to-back bytes SHALL have at least 3 cycles between TxD_start pulses; no byte duplicated or skipped.

Reset
REQ-024 On rst: level = 0, pointers = 0, full = 0, overflow = 0, TxD_start = 0, TxD_data = 0, state = IDLE.
REQ-025 rst mid-transmission SHALL NOT affect the downstream transmitter (it has no reset); after rst, IDLE waits for TxD_busy low before the next launch.
REQ-026 rst with wr_en high SHALL drop the write and leave overflow at 0.

Configuration
REQ-027 With macro UART_TX_FIFO_FLUSH_EN defined, input port flush (1 bit) SHALL exist: on flush, pointers and level go to 0 next cycle, overflow is unchanged, FSM continues its current state; flush with wr_en drops the write without setting overflow.
REQ-028 Without UART_TX_FIFO_FLUSH_EN, the flush port and its logic SHALL be absent.

Verification
REQ-029 Empty FIFO, busy low, write 0x55 at edge N -> TxD_start pulse at N+2 with TxD_data 0x55, level back to 0.
REQ-030 Write 0x01..0x10 (16 bytes, DEPTH_LOG2=4) while busy held high -> full = 1, level = 16, no TxD_start; 17th write 0xAA -> overflow = 1, 0xAA never transmitted.
REQ-031 Transmitter model busy 20 cycles per byte, 3 bytes 0x11,0x22,0x33 -> three pulses in order, each after busy falls, none during busy.
REQ-032 Simultaneous write and pop at level 5 -> level stays 5; at full, write with pop -> byte dropped, overflow = 1.
REQ-033 rst asserted during DRAIN with 4 bytes queued, busy still high -> level 0, TxD_start 0, no launch until busy low and a new write.
REQ-034 With UART_TX_FIFO_FLUSH_EN, flush at level 7 with concurrent wr_en -> level 0 next cycle, overflow unchanged, in-flight byte completes.
